// File: rtl/cpu6_ifu_pkg.sv
// Shared constants for the cpu6 instruction fetch unit.
package cpu6_ifu_pkg;
   localparam int          CPU6_XLEN      = 32;
   localparam logic [31:0] CPU6_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] CPU6_NOP_INSTR = 32'h0000_0013;
   localparam int          CPU6_IFU_DEPTH = 2;

   // Width of a counter that must hold every value from 0 to depth inclusive.
   function automatic int ctrWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/cpu6_fetch_fifo.sv
// Synchronous FIFO with flush; registered storage, 1-cycle push-to-visible latency.
// No internal overflow/underflow protection: the caller guarantees push/pop legality.
module cpu6_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wrPtr] <= pushData;
   end

   assign popData = mem[rdPtr];
   assign count   = cnt;
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
endmodule

// File: rtl/cpu6_ifu.sv
// Instruction fetch: in-order imem requests, buffered {pc,instr} to EX; accept-to-valid 2 cycles.
// Issue stalls while inflight+buffered reaches DEPTH; redirect flushes and squashes in-flight responses.
module cpu6_ifu
   import cpu6_ifu_pkg::*;
#(
   parameter int              XLEN     = CPU6_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU6_RESET_PC),
   parameter int              DEPTH    = CPU6_IFU_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] instr_out
);
   localparam int CW = ctrWidth(DEPTH);

   logic [XLEN-1:0]   fetchPc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     squash;
   logic [CW-1:0]     fifoCount;
   logic [CW-1:0]     tagCount;
   logic [CW:0]       occupancy;
   logic [XLEN-1:0]   rspTag;
   logic [2*XLEN-1:0] bufData;
   logic              reqFire, rspDrop, bufPush, bufPop;
   logic              bufFull, bufEmpty, tagFull, tagEmpty;

   // Every accepted request owns a buffer slot, so the buffer can never overflow.
   assign occupancy      = {1'b0, inflight} + {1'b0, fifoCount};
   assign imem_req_valid = reset && !redirect && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetchPc;
   assign reqFire        = imem_req_valid && imem_req_ready;

   assign rspDrop     = (squash != '0);
   assign bufPush     = imem_rsp_valid && !rspDrop;
   assign instr_valid = !bufEmpty && !redirect;
   assign bufPop      = instr_valid && instr_ready;
   assign pc_out      = instr_valid ? bufData[2*XLEN-1:XLEN] : '0;
   assign instr_out   = instr_valid ? bufData[XLEN-1:0] : XLEN'(CPU6_NOP_INSTR);

   cpu6_fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) tagQueue (
      .clk(clk), .reset(reset), .flush(1'b0),
      .push(reqFire), .pushData(fetchPc),
      .pop(imem_rsp_valid), .popData(rspTag),
      .count(tagCount), .full(tagFull), .empty(tagEmpty)
   );

   cpu6_fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) instrBuf (
      .clk(clk), .reset(reset), .flush(redirect),
      .push(bufPush), .pushData({rspTag, imem_rsp_data}),
      .pop(bufPop), .popData(bufData),
      .count(fifoCount), .full(bufFull), .empty(bufEmpty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetchPc  <= RESET_PC;
         inflight <= '0;
         squash   <= '0;
      end else begin
         case ({reqFire, imem_rsp_valid})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         if (redirect) begin
            // Everything still outstanding after this edge belongs to the wrong path.
            fetchPc <= redirect_pc;
            squash  <= inflight - CW'(imem_rsp_valid);
         end else begin
            if (reqFire) fetchPc <= fetchPc + XLEN'(4);
            if (imem_rsp_valid && rspDrop) squash <= squash - CW'(1);
         end
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         assert (!(imem_rsp_valid && tagEmpty));
         assert (!(reqFire && tagFull));
         assert (!(bufPush && bufFull && !bufPop && !redirect));
         assert (tagCount == inflight);
         assert (squash <= inflight);
         assert (!(redirect && redirect_pc[1:0] != 2'b00));
      end
   end
endmodule

// File: tb/tb_cpu6_ifu.sv
// Scoreboard bench for cpu6_ifu: behavioural imem, directed fetch/stall/redirect/wrap/reset vectors.
module tb_cpu6_ifu;
   logic        clk, reset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] pc_out, instr_out;

   int          nCmp = 0;
   int          nErr = 0;
   logic [31:0] expQ[$];
   logic        rspEn;
   int          reqCnt;
   int          reqBase;

   cpu6_ifu dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc_out(pc_out), .instr_out(instr_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // imem model: 1-cycle response latency when enabled; also checks request ordering and hold.
   initial begin
      logic [31:0] pendQ[$];
      logic [31:0] expAddr, stallAddr;
      logic        stalled, rspGo;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      reqCnt = 0;
      stalled = 1'b0;
      rspGo = 1'b0;
      expAddr = 32'h0;
      stallAddr = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pendQ.delete();
            expAddr = 32'h0;
            stalled = 1'b0;
            rspGo   = 1'b0;
         end else begin
            if (stalled && !redirect) begin
               check("req_hold_vld", {31'b0, imem_req_valid}, 32'd1);
               check("req_hold_addr", imem_req_addr, stallAddr);
            end
            stalled   = imem_req_valid && !imem_req_ready;
            stallAddr = imem_req_addr;
            if (imem_req_valid && imem_req_ready) begin
               check("req_addr", imem_req_addr, expAddr);
               expAddr = expAddr + 32'd4;
               pendQ.push_back(imem_req_addr);
               reqCnt++;
            end
            if (redirect) expAddr = redirect_pc;
            rspGo = rspEn;
         end
         @(posedge clk);
         #1;
         if (reset && rspGo && pendQ.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pendQ.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Monitor: every completed handshake is checked against the expected-PC queue.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (instr_valid && instr_ready) begin
            if (expQ.size() == 0) begin
               nCmp++;
               nErr++;
               $display("FAIL unexpected_instr: got pc %h with empty expectation queue", pc_out);
            end else begin
               e = expQ.pop_front();
               check("pc_out", pc_out, e);
               check("instr_out", instr_out, memWord(e));
            end
         end
      end
   end

   task automatic runExp(input int budget, input bit toggleReq);
      int n;
      n = 0;
      instr_ready = 1'b1;
      while (expQ.size() != 0 && n < budget) begin
         tick;
         if (toggleReq) imem_req_ready = ~imem_req_ready;
         n++;
      end
      if (expQ.size() != 0) begin
         nCmp++;
         nErr++;
         $display("FAIL drain_timeout: %0d instructions still expected after %0d cycles", expQ.size(), n);
         expQ.delete();
      end
      instr_ready    = 1'b0;
      imem_req_ready = 1'b1;
   endtask

   task automatic restart(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      reqBase     = reqCnt;
      @(negedge clk);
      check("redir_ivld_mask", {31'b0, instr_valid}, 32'd0);
      check("redir_req_mask", {31'b0, imem_req_valid}, 32'd0);
      tick;
      redirect = 1'b0;
   endtask

   task automatic pushExp(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(base + 32'(4 * i));
   endtask

   initial begin
      int n;
      reset = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      instr_ready = 1'b0;
      rspEn = 1'b1;
      reqBase = 0;
      @(posedge clk);
      #2;
      check("rst_req_vld", {31'b0, imem_req_valid}, 32'd0);
      check("rst_ivld", {31'b0, instr_valid}, 32'd0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_instr_out", instr_out, 32'h0000_0013);
      tick;

      // Streaming after reset release: first instruction two cycles after the first request.
      pushExp(32'h0, 5);
      reset = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      check("c0_req_vld", {31'b0, imem_req_valid}, 32'd1);
      check("c0_ivld", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      check("c1_ivld", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
      check("c2_ivld", {31'b0, instr_valid}, 32'd1);
      tick;
      runExp(60, 1'b0);

      // Downstream stall: two fetched and buffered, output held.
      restart(32'h0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!instr_valid && n < 20);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("stall_pc", pc_out, 32'h0);
         check("stall_instr", instr_out, memWord(32'h0));
      end
      check("stall_req_vld", {31'b0, imem_req_valid}, 32'd0);
      check("stall_req_cnt", 32'(reqCnt - reqBase), 32'd2);
      tick;
      pushExp(32'h0, 4);
      runExp(60, 1'b0);

      // imem back-pressure toggling.
      restart(32'h40);
      pushExp(32'h40, 5);
      runExp(80, 1'b1);

      // Redirect while two responses are in flight.
      repeat (6) tick;
      rspEn = 1'b0;
      restart(32'h80);
      repeat (4) tick;
      check("p4_inflight_reqs", 32'(reqCnt - reqBase), 32'd2);
      pushExp(32'h100, 3);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      rspEn = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      check("p4_redir_ivld", {31'b0, instr_valid}, 32'd0);
      tick;
      redirect = 1'b0;
      runExp(60, 1'b0);

      // Redirect coinciding with a response, then a second redirect before the squash drains.
      repeat (6) tick;
      rspEn = 1'b0;
      restart(32'h180);
      repeat (4) tick;
      pushExp(32'h200, 3);
      rspEn = 1'b1;
      tick;
      redirect = 1'b1;
      redirect_pc = 32'h1C0;
      rspEn = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      check("p5_rsp_with_redir", {31'b0, imem_rsp_valid}, 32'd1);
      check("p5_redir1_ivld", {31'b0, instr_valid}, 32'd0);
      tick;
      redirect_pc = 32'h200;
      rspEn = 1'b1;
      tick;
      redirect = 1'b0;
      runExp(60, 1'b0);

      // Fetch PC wraps past the top of the address space.
      repeat (6) tick;
      restart(32'hFFFF_FFF8);
      pushExp(32'hFFFF_FFF8, 4);
      runExp(60, 1'b0);

      // Async reset in the middle of a stalled stream.
      restart(32'h300);
      pushExp(32'h300, 2);
      runExp(40, 1'b0);
      repeat (4) tick;
      check("pre_rst_ivld", {31'b0, instr_valid}, 32'd1);
      #3;
      reset = 1'b0;
      #1;
      check("arst_req_vld", {31'b0, imem_req_valid}, 32'd0);
      check("arst_ivld", {31'b0, instr_valid}, 32'd0);
      check("arst_pc_out", pc_out, 32'h0);
      check("arst_instr_out", instr_out, 32'h0000_0013);
      tick;
      tick;
      pushExp(32'h0, 3);
      reset = 1'b1;
      runExp(60, 1'b0);

      repeat (3) tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/cpu6_ifu.md
Name: cpu6_ifu

Overview:
- Instruction fetch unit. Sits directly upstream of the EX/MEM/WB datapath and supplies its pcE/instrE pair.
- Owns the architectural fetch PC and issues in-order requests to the instruction memory over a valid/ready request channel. In-order responses return on a separate channel.
- Buffers returned instructions with their PCs in a small FIFO. Presents them to decode/EX with a valid/ready handshake.
- Accepts redirects from EX (pcsrcE/pcnextE): flushes all wrong-path state and squashes in-flight responses.

Parameters:
- XLEN, 32, datapath/address width (matches CPU6_XLEN).
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, fetch buffer entries; also the maximum number of in-flight requests (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  response data valid (in order, >=1 cycle after acceptance).
- imem_rsp_data  in  XLEN  instruction word.
- redirect  in  1  pcsrcE from EX; flush and refetch.
- redirect_pc  in  XLEN  pcnextE from EX; new fetch PC.
- instr_valid  out  1  pc_out/instr_out hold a valid instruction.
- instr_ready  in  1  downstream accepts the instruction.
- pc_out  out  XLEN  PC of the presented instruction.
- instr_out  out  XLEN  instruction word (NOP 32'h00000013 when not valid).

Behaviour:
- Reset (reset==0, async): fetch_pc=RESET_PC; FIFO empty; inflight=0; squash=0. Outputs: imem_req_valid=0, instr_valid=0, pc_out=0, instr_out=NOP.
- State:
  - fetch_pc.
  - inflight counter (0..DEPTH).
  - squash counter (0..DEPTH): number of pending responses to drop.
  - PC tag queue: DEPTH entries, holds the address of each accepted request.
  - FIFO: DEPTH entries of {pc, instr}.
- Request issue: imem_req_valid = !redirect && (inflight + fifo_count < DEPTH). imem_req_addr = fetch_pc.
- Request acceptance: when valid && ready, push fetch_pc to the tag queue, inflight+1, fetch_pc += 4 (wraps modulo 2^XLEN). imem_req_valid never deasserts without acceptance unless redirect is high.
- Response handling on imem_rsp_valid: pop the tag queue and decrement inflight.
  - If squash>0: discard the data and decrement squash.
  - Otherwise push {tag, data} into the FIFO.
  - Space is guaranteed by the issue rule; overflow is an assertion failure.
- Output: instr_valid = fifo_not_empty && !redirect. instr_valid is combinationally masked while redirect is high, so no handshake can complete in a redirect cycle. The FIFO pops on instr_valid && instr_ready.
- Latency: a request accepted in cycle N with its response in N+1 gives instr_valid in N+2 (registered FIFO output). Back-to-back throughput is 1 instruction/cycle when imem responds in 1 cycle and downstream is ready.
- Redirect (next edge):
  - fetch_pc <= redirect_pc.
  - FIFO cleared.
  - squash <= inflight minus any response arriving in the same cycle.
  - inflight/tag queue keep tracking the outstanding responses.
  - No new request is issued in the redirect cycle; issue resumes the next cycle from redirect_pc.
- Redirect while squash>0: squash accumulates and stays bounded by inflight.
- Simultaneous response + pop on a full FIFO: legal; count unchanged.
- Simultaneous acceptance + response: inflight unchanged, tag queue push and pop together.
- redirect_pc[1:0] != 0: the value is used as-is. Misalignment is flagged by a simulation assertion only.
- Stall: instr_ready=0 holds pc_out/instr_out stable. Issue stops once inflight + fifo_count == DEPTH.
- Reset mid-operation: all counters and queues clear immediately. Any imem response arriving after reset deassert without a matching request is an environment error.

Decomposition:
- defines.v additions:
  - CPU6_RESET_PC.
  - CPU6_NOP_INSTR (32'h00000013).
  - CPU6_IFU_DEPTH.
- One sub-module: cpu6_fetch_fifo. Parameterised width/depth synchronous FIFO with flush, count, and full/empty outputs. It is instantiated twice: once for the tag queue (XLEN wide) and once for the instruction buffer (2*XLEN wide).
- Top-level control (counters, issue, squash) lives in cpu6_ifu.

Test Plan:
- Reset release, imem 1-cycle latency, instr_ready=1 -> requests 0x0,0x4,0x8,…; instr_valid from cycle 2; pc_out sequence 0x0,0x4,0x8 one per cycle.
- instr_ready=0 for 5 cycles after the first instruction -> exactly 2 requests outstanding/buffered; pc_out/instr_out held at 0x0; resume gives 0x4, 0x8 with no drop or duplicate.
- imem_req_ready toggling 1,0,1,0 -> imem_req_addr held stable while not ready; addresses strictly +4 per acceptance.
- redirect with redirect_pc=0x100 while 2 responses are in flight -> instr_valid=0 in the redirect cycle; both stale responses dropped; next pc_out=0x100 with instr from 0x100.
- redirect in the same cycle as a response, then a second redirect to 0x200 before the squash drains -> only instructions from 0x200 onward are presented.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000; async reset asserted mid-stream -> outputs return to reset values in the same cycle, and fetch restarts at RESET_PC.
